// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpu_pkg
// Description : Shared width helpers and mode constants for the multi-lane
//               dot-product accumulator (tpu_dot_accum) and its lanes.
// Revision    : 1.0 - initial release
// ============================================================================
package tpu_pkg;

    // Operand interpretation selected by in_signed.
    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // Accumulator width: the result spans both output halves.
    function automatic int acc_width(input int out_w);
        return 2 * out_w;
    endfunction

    // Width of the per-beat lane sum: one product plus carry growth of the tree.
    function automatic int sum_width(input int data_w, input int lanes);
        return 2 * data_w + $clog2(lanes);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tpu_mac_lane.sv
`default_nettype none
// ============================================================================
// Module      : tpu_mac_lane
// Description : One DATA_W x DATA_W multiplier with signed/unsigned select.
//               Purely combinational; the caller registers the product.
// Ports       : a_i, b_i   - operands (DATA_W each)
//               signed_i   - MODE_SIGNED treats operands as two's complement
//               prod_o     - 2*DATA_W product (exact in both modes)
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_mac_lane
    import tpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    input  logic                signed_i,
    output logic [2*DATA_W-1:0] prod_o
);

    localparam int PROD_W = 2 * DATA_W;

    // One extra bit lets a single signed multiplier serve both modes: the
    // extension bit is the operand MSB in signed mode and 0 in unsigned mode.
    logic signed [DATA_W:0]   a_ext;
    logic signed [DATA_W:0]   b_ext;
    logic signed [PROD_W-1:0] full;

    assign a_ext  = {(signed_i == MODE_SIGNED) && a_i[DATA_W-1], a_i};
    assign b_ext  = {(signed_i == MODE_SIGNED) && b_i[DATA_W-1], b_i};

    // The exact product always fits in PROD_W bits in either mode.
    assign full   = PROD_W'(a_ext) * PROD_W'(b_ext);
    assign prod_o = full;

endmodule
`default_nettype wire

// File: rtl/tpu_dot_accum.sv
`default_nettype none
// ============================================================================
// Module      : tpu_dot_accum
// Description : Pipelined LANES-wide multiply-accumulate engine. Accumulates a
//               dot product across beats until a beat flagged last, then
//               presents the result in a one-entry output register.
// Ports       : clk, reset (async, active low)
//               in_valid/in_ready, in_a/in_b (LANES*DATA_W), in_signed,
//               in_last                       - operand beat handshake
//               out_valid/out_ready, out_HL, out (OUT_W), error
//                                             - result register and readout
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_dot_accum
    import tpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int OUT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_a,
    input  logic [LANES*DATA_W-1:0]   in_b,
    input  logic                      in_signed,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    input  logic                      out_HL,
    output logic [OUT_W-1:0]          out,
    output logic                      error
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = acc_width(OUT_W);
    localparam int SUM_W  = sum_width(DATA_W, LANES);
    // Wide enough to hold acc + sum exactly in either mode.
    localparam int EXT_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic en;
    logic accept;

    logic              p1_valid_q;
    logic              p1_last_q;
    logic              p1_signed_q;
    logic [PROD_W-1:0] p1_prod_q [LANES];
    logic [PROD_W-1:0] lane_prod [LANES];

    logic              out_valid_q;

    // Only a finished vector waiting on a full, unread result register stalls.
    assign en       = !(p1_valid_q && p1_last_q && out_valid_q && !out_ready);
    assign in_ready = en;
    assign accept   = in_valid && en;

    // ------------------------------------------------------------------
    // Mode latch: the first beat of each vector decides the mode
    // ------------------------------------------------------------------
    logic first_q;
    logic mode_q;
    logic eff_mode;

    assign eff_mode = first_q ? in_signed : mode_q;

    // ------------------------------------------------------------------
    // Stage P1: per-lane products
    // ------------------------------------------------------------------
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        tpu_mac_lane #(
            .DATA_W (DATA_W)
        ) u_lane (
            .a_i      (in_a[i*DATA_W +: DATA_W]),
            .b_i      (in_b[i*DATA_W +: DATA_W]),
            .signed_i (eff_mode),
            .prod_o   (lane_prod[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1_valid_q  <= 1'b0;
            p1_last_q   <= 1'b0;
            p1_signed_q <= MODE_UNSIGNED;
            first_q     <= 1'b1;
            mode_q      <= MODE_UNSIGNED;
            for (int i = 0; i < LANES; i++) begin
                p1_prod_q[i] <= '0;
            end
        end else if (en) begin
            p1_valid_q <= accept;
            if (accept) begin
                p1_prod_q   <= lane_prod;
                p1_last_q   <= in_last;
                p1_signed_q <= eff_mode;
                first_q     <= in_last;
                mode_q      <= eff_mode;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage P2: lane sum, accumulate, overflow detection
    // ------------------------------------------------------------------
    logic [SUM_W-1:0]       sum_w;
    logic [EXT_W-1:0]       acc_ext;
    logic [EXT_W-1:0]       sum_ext;
    logic [EXT_W-1:0]       exact;
    logic [EXT_W-ACC_W:0]   top_bits;
    logic                   ovf_now;

    logic [ACC_W-1:0]       acc_q, acc_d;
    logic                   ovf_sticky_q, ovf_sticky_d;
    logic [ACC_W-1:0]       result_q, result_d;
    logic                   res_err_q, res_err_d;
    logic                   out_valid_d;
    logic                   consume;

    always_comb begin
        sum_w = '0;
        for (int i = 0; i < LANES; i++) begin
            if (p1_signed_q == MODE_SIGNED) begin
                sum_w = sum_w + SUM_W'($signed(p1_prod_q[i]));
            end else begin
                sum_w = sum_w + SUM_W'(p1_prod_q[i]);
            end
        end
    end

    always_comb begin
        if (p1_signed_q == MODE_SIGNED) begin
            acc_ext = EXT_W'($signed(acc_q));
            sum_ext = EXT_W'($signed(sum_w));
        end else begin
            acc_ext = EXT_W'(acc_q);
            sum_ext = EXT_W'(sum_w);
        end
        exact    = acc_ext + sum_ext;
        top_bits = exact[EXT_W-1:ACC_W-1];
        // Unsigned: anything above the accumulator is overflow.
        // Signed: the bits from the ACC_W sign bit upward must all agree.
        if (p1_signed_q == MODE_SIGNED) begin
            ovf_now = !((&top_bits) || (~|top_bits));
        end else begin
            ovf_now = |exact[EXT_W-1:ACC_W];
        end
    end

    assign consume = en && p1_valid_q;

    always_comb begin
        acc_d        = acc_q;
        ovf_sticky_d = ovf_sticky_q;
        result_d     = result_q;
        res_err_d    = res_err_q;
        out_valid_d  = out_valid_q;

        // A pop clears the register unless a new result lands in the same
        // cycle, in which case the write wins and no bubble appears.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (consume) begin
            if (p1_last_q) begin
                result_d     = exact[ACC_W-1:0];
                res_err_d    = ovf_sticky_q | ovf_now;
                out_valid_d  = 1'b1;
                acc_d        = '0;
                ovf_sticky_d = 1'b0;
            end else begin
                acc_d        = exact[ACC_W-1:0];
                ovf_sticky_d = ovf_sticky_q | ovf_now;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q        <= '0;
            ovf_sticky_q <= 1'b0;
            result_q     <= '0;
            res_err_q    <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            ovf_sticky_q <= ovf_sticky_d;
            result_q     <= result_d;
            res_err_q    <= res_err_d;
            out_valid_q  <= out_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Readout
    // ------------------------------------------------------------------
    assign out_valid = out_valid_q;
    assign out       = out_HL ? result_q[ACC_W-1:OUT_W] : result_q[OUT_W-1:0];
    assign error     = out_valid_q & res_err_q;

endmodule
`default_nettype wire

// File: doc/tpu_dot_accum.md
Name: tpu_dot_accum

Overview:
Parametrised, pipelined multi-lane multiply-accumulate engine; successor to the single-lane TPU_functional MAC.
Accepts LANES operand pairs per beat over a valid/ready handshake and accumulates a dot product across beats until a beat flagged last.
Presents the finished result through a one-entry output register with a high/low half select.
Supports signed and unsigned modes and flags accumulator overflow per result.

Parameters:
DATA_W, 8, width of each operand element
LANES, 4, operand pairs multiplied per beat
OUT_W, 16, output port width; ACC_W is fixed at 2*OUT_W (accumulator width)

Ports:
clk  input  1  single rising-edge clock
reset  input  1  asynchronous, active-low reset; clears all state when 0
in_valid  input  1  operand beat present
in_ready  output  1  engine accepts a beat this cycle
in_a  input  LANES*DATA_W  operand A; lane i at bits [i*DATA_W +: DATA_W]
in_b  input  LANES*DATA_W  operand B, same packing
in_signed  input  1  1 = two's-complement operands, 0 = unsigned
in_last  input  1  beat is the final beat of the current vector
out_valid  output  1  result register holds an unread result
out_ready  input  1  consumer pops the result
out_HL  input  1  0 = out shows result[OUT_W-1:0]; 1 = out shows result[ACC_W-1:OUT_W]
out  output  OUT_W  selected result half; combinational mux on out_HL
error  output  1  overflow flag of the held result; 0 when out_valid = 0

Behaviour:
- Reset (reset = 0, asynchronous): out_valid = 0, error = 0, out = 0, in_ready = 1, all pipeline valids = 0, accumulator = 0, mode latch = 0. Asserting reset mid-vector discards the partial sum; no result is produced for it.
- Beat accepted when in_valid && in_ready.
- Stage P1, one cycle: LANES products registered, each 2*DATA_W wide, plus p1_valid, p1_last and p1_signed.
- Mode: in_signed is latched on the first beat of each vector; in_signed on later beats of that vector is ignored.
- Stage P2: products summed in an adder tree of width 2*DATA_W + clog2(LANES), sign- or zero-extended per mode, then added to the accumulator.
  - If p1_last = 0: acc <= acc + sum.
  - If p1_last = 1: result <= acc + sum, res_err <= ovf_sticky | ovf_now, out_valid <= 1; then acc <= 0 and ovf_sticky <= 0.
- Overflow is set when the exact mathematical sum is not representable in ACC_W bits (signed or unsigned range per mode).
  - The flag is sticky for the rest of the vector.
  - The wrapped value (mod 2^ACC_W) is still stored.
- Latency: last beat accepted in cycle t gives out_valid = 1 from cycle t+2.
- Pop: out_valid && out_ready clears out_valid next cycle unless a new result is written in the same cycle. Simultaneous pop and write loads the new result, keeps out_valid = 1, and inserts no bubble.
- Stall condition: en = !(p1_valid && p1_last && out_valid && !out_ready).
  - in_ready = en.
  - When en = 0, P1 holds its contents and no beat is accepted.
  - Non-last P1 beats never stall.
- A single-beat vector (in_last on the first beat) is legal.
- Throughput is one beat per cycle with no backpressure.
- error reflects res_err only; it is not sticky across results.

Decomposition:
- Shared package tpu_pkg:
  - ACC_W derivation function (2*OUT_W).
  - Adder-tree sum-width function (2*DATA_W + clog2(LANES)).
  - Mode constants MODE_UNSIGNED = 0 and MODE_SIGNED = 1.
- Sub-module tpu_mac_lane: one DATA_W x DATA_W multiplier with a signed/unsigned select, producing a 2*DATA_W product; instantiated LANES times inside P1.

Test Plan:
1. Unsigned, single beat, lane0 a=13 b=15, other lanes 0, last=1 -> out_valid at t+2; out_HL=0 gives out=195; out_HL=1 gives out=0; error=0.
2. Unsigned, two beats (13*15, then 41*47 with last) -> single result 2122 (0x084A), out_HL=1 gives 0; only one out_valid pulse.
3. Signed, lane0 a=0x89 (-119) b=9 last -> result 0xFFFFFBD1; out_HL=0 gives 0xFBD1, out_HL=1 gives 0xFFFF. The same operands unsigned give 1233 (0x04D1) and a high half of 0.
4. OUT_W=8 (ACC_W=16), unsigned, all 4 lanes a=b=255, last -> error=1, out_HL=0 gives 0x04; next vector 1*1 gives result 1 with error=0.
5. out_ready=0, two back-to-back single-beat vectors (2*3 then 4*5) -> first result 6 held; in_ready drops while second last sits in P1. Raising out_ready pops 6, then 20 appears on the next cycle; nothing lost or duplicated.
6. Reset pulsed low mid-vector after beat 7*7 -> all outputs return to reset values asynchronously. A fresh vector 2*2 last yields 4, not 53.
